// File: rtl/idu_ir_rename.sv
// Rename stage: one-entry decode buffer, 32-entry arch->preg map, ROB/PST create on fire.
// Optional IDU_IR_PERF_EN adds perf_create_cnt/perf_stall_cnt event counters.
module idu_ir_rename #(
  parameter int NUM_GPR = 32,
  parameter int PREG_W  = 6,
  parameter int IID_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_clk,
  input  logic                      rtu_global_flush,
  input  logic                      y_idu_ir_stall_ctrl,
  input  logic                      idu_idu_ir_vld,
  input  logic [6:0]                idu_idu_ir_opcode,
  input  logic [2:0]                idu_idu_ir_funct3,
  input  logic [63:0]               idu_idu_ir_pc,
  input  logic                      idu_idu_ir_src1_vld,
  input  logic [4:0]                idu_idu_ir_src1,
  input  logic                      idu_idu_ir_src2_vld,
  input  logic [4:0]                idu_idu_ir_src2,
  input  logic                      idu_idu_ir_dst_vld,
  input  logic [4:0]                idu_idu_ir_dst,
  input  logic                      idu_idu_ir_imm_vld,
  input  logic [63:0]               idu_idu_ir_imm,
  input  logic [5:0]                idu_idu_ir_type,
  input  logic [4:0]                idu_idu_ir_pipe,
  input  logic                      idu_idu_ir_ras,
  output logic                      idu_ir_id_stall,
  input  logic                      rtu_idu_is_iid_vld,
  input  logic [IID_W-1:0]          rtu_idu_is_iid,
  input  logic                      rtu_idu_is_preg_vld,
  input  logic [PREG_W-1:0]         rtu_idu_is_preg,
  input  logic [NUM_GPR*PREG_W-1:0] rtu_idu_ir_recover_table,
  output logic                      idu_rtu_rob_create_vld,
  output logic [6:0]                idu_rtu_rob_create_opcode,
  output logic [2:0]                idu_rtu_rob_create_funct3,
  output logic [63:0]               idu_rtu_rob_create_pc,
  output logic [4:0]                idu_rtu_rob_create_src1,
  output logic                      idu_rtu_rob_create_src1_vld,
  output logic [PREG_W-1:0]         idu_rtu_rob_create_psrc1,
  output logic [4:0]                idu_rtu_rob_create_src2,
  output logic                      idu_rtu_rob_create_src2_vld,
  output logic [PREG_W-1:0]         idu_rtu_rob_create_psrc2,
  output logic [4:0]                idu_rtu_rob_create_dst,
  output logic                      idu_rtu_rob_create_dst_vld,
  output logic [PREG_W-1:0]         idu_rtu_rob_create_pdst,
  output logic [63:0]               idu_rtu_rob_create_imm,
  output logic                      idu_rtu_rob_create_imm_vld,
  output logic [5:0]                idu_rtu_rob_create_type,
  output logic [4:0]                idu_rtu_rob_create_pipe,
  output logic                      idu_rtu_rob_create_ras,
  output logic                      idu_rtu_pst_create_vld,
  output logic [PREG_W-1:0]         idu_rtu_pst_create_preg_index,
  output logic [IID_W-1:0]          idu_rtu_pst_create_iid,
  output logic [4:0]                idu_rtu_pst_create_gpr_index,
  output logic [PREG_W-1:0]         idu_rtu_pst_create_gpr_pre_preg_index
`ifdef IDU_IR_PERF_EN
  ,
  output logic [31:0]               perf_create_cnt,
  output logic [31:0]               perf_stall_cnt
`endif
);

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [63:0] pc;
    logic        src1_vld;
    logic [4:0]  src1;
    logic        src2_vld;
    logic [4:0]  src2;
    logic        dst_vld;
    logic [4:0]  dst;
    logic        imm_vld;
    logic [63:0] imm;
    logic [5:0]  itype;
    logic [4:0]  pipe;
    logic        ras;
  } ir_t;

  ir_t               r_buf;
  logic              r_buf_vld;
  logic [PREG_W-1:0] r_table [NUM_GPR];

  ir_t               w_in;
  logic              w_need_preg;
  logic              w_fire;
  logic              w_accept;
  logic              w_pst_vld;
  logic [PREG_W-1:0] w_psrc1;
  logic [PREG_W-1:0] w_psrc2;
  logic [PREG_W-1:0] w_pre_preg;

  assign w_in = {idu_idu_ir_opcode, idu_idu_ir_funct3, idu_idu_ir_pc,
                 idu_idu_ir_src1_vld, idu_idu_ir_src1, idu_idu_ir_src2_vld, idu_idu_ir_src2,
                 idu_idu_ir_dst_vld, idu_idu_ir_dst, idu_idu_ir_imm_vld, idu_idu_ir_imm,
                 idu_idu_ir_type, idu_idu_ir_pipe, idu_idu_ir_ras};

  // A write to x0 needs no preg and is reported downstream as having no destination.
  assign w_need_preg = r_buf.dst_vld && (r_buf.dst != 5'd0);
  assign w_fire      = r_buf_vld && rtu_idu_is_iid_vld && (!w_need_preg || rtu_idu_is_preg_vld)
                       && !y_idu_ir_stall_ctrl && !rtu_global_flush;
  assign w_accept    = (!r_buf_vld || w_fire) && !rtu_global_flush;
  assign w_pst_vld   = w_fire && w_need_preg;

  assign w_psrc1    = r_buf.src1_vld ? r_table[r_buf.src1] : '0;
  assign w_psrc2    = r_buf.src2_vld ? r_table[r_buf.src2] : '0;
  assign w_pre_preg = r_table[r_buf.dst];

  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      r_buf_vld <= 1'b0;
      r_buf     <= '0;
    end else if (rtu_global_flush) begin
      r_buf_vld <= 1'b0;
    end else if (w_accept) begin
      r_buf_vld <= idu_idu_ir_vld;
      r_buf     <= w_in;
    end
  end

  // Entry 0 is pinned to preg 0: reset and recover both force it, and creates never target x0.
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      for (int i = 0; i < NUM_GPR; i++) r_table[i] <= PREG_W'(i);
    end else if (rtu_global_flush) begin
      r_table[0] <= '0;
      for (int i = 1; i < NUM_GPR; i++) r_table[i] <= rtu_idu_ir_recover_table[i*PREG_W +: PREG_W];
    end else if (w_pst_vld) begin
      r_table[r_buf.dst] <= rtu_idu_is_preg;
    end
  end

  assign idu_ir_id_stall = r_buf_vld && !w_fire;

  assign idu_rtu_rob_create_vld      = w_fire;
  assign idu_rtu_rob_create_opcode   = w_fire ? r_buf.opcode : '0;
  assign idu_rtu_rob_create_funct3   = w_fire ? r_buf.funct3 : '0;
  assign idu_rtu_rob_create_pc       = w_fire ? r_buf.pc : '0;
  assign idu_rtu_rob_create_src1     = w_fire ? r_buf.src1 : '0;
  assign idu_rtu_rob_create_src1_vld = w_fire && r_buf.src1_vld;
  assign idu_rtu_rob_create_psrc1    = w_fire ? w_psrc1 : '0;
  assign idu_rtu_rob_create_src2     = w_fire ? r_buf.src2 : '0;
  assign idu_rtu_rob_create_src2_vld = w_fire && r_buf.src2_vld;
  assign idu_rtu_rob_create_psrc2    = w_fire ? w_psrc2 : '0;
  assign idu_rtu_rob_create_dst      = w_fire ? r_buf.dst : '0;
  assign idu_rtu_rob_create_dst_vld  = w_pst_vld;
  assign idu_rtu_rob_create_pdst     = w_pst_vld ? rtu_idu_is_preg : '0;
  assign idu_rtu_rob_create_imm      = w_fire ? r_buf.imm : '0;
  assign idu_rtu_rob_create_imm_vld  = w_fire && r_buf.imm_vld;
  assign idu_rtu_rob_create_type     = w_fire ? r_buf.itype : '0;
  assign idu_rtu_rob_create_pipe     = w_fire ? r_buf.pipe : '0;
  assign idu_rtu_rob_create_ras      = w_fire && r_buf.ras;

  assign idu_rtu_pst_create_vld                = w_pst_vld;
  assign idu_rtu_pst_create_preg_index         = w_pst_vld ? rtu_idu_is_preg : '0;
  assign idu_rtu_pst_create_iid                = w_pst_vld ? rtu_idu_is_iid : '0;
  assign idu_rtu_pst_create_gpr_index          = w_pst_vld ? r_buf.dst : '0;
  assign idu_rtu_pst_create_gpr_pre_preg_index = w_pst_vld ? w_pre_preg : '0;

`ifdef IDU_IR_PERF_EN
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      perf_create_cnt <= '0;
      perf_stall_cnt  <= '0;
    end else begin
      if (w_fire) perf_create_cnt <= perf_create_cnt + 32'd1;
      if (r_buf_vld && !w_fire && !rtu_global_flush) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_idu_ir_rename.sv
// Scoreboard bench for idu_ir_rename: directed scenarios then random traffic against an array map model.
module tb_idu_ir_rename;
  localparam int NUM_GPR = 32;
  localparam int PREG_W  = 6;
  localparam int IID_W   = 4;

  typedef struct packed {
    logic        vld;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [63:0] pc;
    logic        src1_vld;
    logic [4:0]  src1;
    logic        src2_vld;
    logic [4:0]  src2;
    logic        dst_vld;
    logic [4:0]  dst;
    logic        imm_vld;
    logic [63:0] imm;
    logic [5:0]  itype;
    logic [4:0]  pipe;
    logic        ras;
  } ins_t;

  logic clk = 1'b0;
  logic rst_clk = 1'b1;
  always #5 clk = ~clk;

  ins_t in_i = '0;
  logic flush = 1'b0, stall_ctrl = 1'b0;
  logic iid_vld = 1'b0, preg_vld = 1'b0;
  logic [IID_W-1:0] iid = '0;
  logic [PREG_W-1:0] preg = '0;
  logic [NUM_GPR*PREG_W-1:0] rec = '0;

  logic id_stall, rob_vld, pst_vld;
  logic [6:0] rob_opcode; logic [2:0] rob_funct3; logic [63:0] rob_pc, rob_imm;
  logic [4:0] rob_src1, rob_src2, rob_dst, rob_pipe, pst_gpr;
  logic rob_src1_vld, rob_src2_vld, rob_dst_vld, rob_imm_vld, rob_ras;
  logic [PREG_W-1:0] rob_psrc1, rob_psrc2, rob_pdst, pst_preg, pst_pre;
  logic [5:0] rob_type; logic [IID_W-1:0] pst_iid;
`ifdef IDU_IR_PERF_EN
  logic [31:0] perf_create_cnt, perf_stall_cnt;
`endif

  idu_ir_rename #(.NUM_GPR(NUM_GPR), .PREG_W(PREG_W), .IID_W(IID_W)) dut (
    .clk(clk), .rst_clk(rst_clk), .rtu_global_flush(flush), .y_idu_ir_stall_ctrl(stall_ctrl),
    .idu_idu_ir_vld(in_i.vld), .idu_idu_ir_opcode(in_i.opcode), .idu_idu_ir_funct3(in_i.funct3),
    .idu_idu_ir_pc(in_i.pc), .idu_idu_ir_src1_vld(in_i.src1_vld), .idu_idu_ir_src1(in_i.src1),
    .idu_idu_ir_src2_vld(in_i.src2_vld), .idu_idu_ir_src2(in_i.src2),
    .idu_idu_ir_dst_vld(in_i.dst_vld), .idu_idu_ir_dst(in_i.dst),
    .idu_idu_ir_imm_vld(in_i.imm_vld), .idu_idu_ir_imm(in_i.imm), .idu_idu_ir_type(in_i.itype),
    .idu_idu_ir_pipe(in_i.pipe), .idu_idu_ir_ras(in_i.ras), .idu_ir_id_stall(id_stall),
    .rtu_idu_is_iid_vld(iid_vld), .rtu_idu_is_iid(iid), .rtu_idu_is_preg_vld(preg_vld),
    .rtu_idu_is_preg(preg), .rtu_idu_ir_recover_table(rec),
    .idu_rtu_rob_create_vld(rob_vld), .idu_rtu_rob_create_opcode(rob_opcode),
    .idu_rtu_rob_create_funct3(rob_funct3), .idu_rtu_rob_create_pc(rob_pc),
    .idu_rtu_rob_create_src1(rob_src1), .idu_rtu_rob_create_src1_vld(rob_src1_vld),
    .idu_rtu_rob_create_psrc1(rob_psrc1), .idu_rtu_rob_create_src2(rob_src2),
    .idu_rtu_rob_create_src2_vld(rob_src2_vld), .idu_rtu_rob_create_psrc2(rob_psrc2),
    .idu_rtu_rob_create_dst(rob_dst), .idu_rtu_rob_create_dst_vld(rob_dst_vld),
    .idu_rtu_rob_create_pdst(rob_pdst), .idu_rtu_rob_create_imm(rob_imm),
    .idu_rtu_rob_create_imm_vld(rob_imm_vld), .idu_rtu_rob_create_type(rob_type),
    .idu_rtu_rob_create_pipe(rob_pipe), .idu_rtu_rob_create_ras(rob_ras),
    .idu_rtu_pst_create_vld(pst_vld), .idu_rtu_pst_create_preg_index(pst_preg),
    .idu_rtu_pst_create_iid(pst_iid), .idu_rtu_pst_create_gpr_index(pst_gpr),
    .idu_rtu_pst_create_gpr_pre_preg_index(pst_pre)
`ifdef IDU_IR_PERF_EN
    , .perf_create_cnt(perf_create_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int n_chk = 0, n_pass = 0;
  ins_t q[$];
  logic [PREG_W-1:0] map [NUM_GPR];
  int unsigned m_create = 0, m_stall = 0;
  ins_t b;
  bit has, need, f;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: the pending instruction queue plus an architectural map array.
  always @(negedge clk) begin
    if (rst_clk) begin
      q.delete();
      for (int i = 0; i < NUM_GPR; i++) map[i] = PREG_W'(i);
      m_create = 0;
      m_stall  = 0;
    end else begin
      has = (q.size() > 0);
      b = has ? q[0] : '0;
      need = has && b.dst_vld && (b.dst != 0);
      f = has && iid_vld && (!need || preg_vld) && !stall_ctrl && !flush;
      chk("rob_create_vld", rob_vld, f);
      chk("pst_create_vld", pst_vld, f && need);
      chk("id_stall", id_stall, has && !f);
      if (f && rob_vld) begin
        chk("rob_fields", {rob_opcode, rob_funct3, rob_pc, rob_src1, rob_src1_vld, rob_src2,
                           rob_src2_vld, rob_dst, rob_imm, rob_imm_vld, rob_type, rob_pipe, rob_ras},
            {b.opcode, b.funct3, b.pc, b.src1, b.src1_vld, b.src2, b.src2_vld, b.dst,
             b.imm, b.imm_vld, b.itype, b.pipe, b.ras});
        chk("rob_psrc", {rob_psrc1, rob_psrc2},
            {b.src1_vld ? map[b.src1] : 6'd0, b.src2_vld ? map[b.src2] : 6'd0});
        chk("rob_pdst", {rob_dst_vld, rob_pdst}, {need, need ? preg : 6'd0});
        if (need)
          chk("pst_payload", {pst_preg, pst_iid, pst_gpr, pst_pre}, {preg, iid, b.dst, map[b.dst]});
      end
      if (f) begin
        if (need) map[b.dst] = preg;
        void'(q.pop_front());
        m_create++;
      end else if (has && !flush) begin
        m_stall++;
      end
      if (flush) begin
        q.delete();
        for (int i = 0; i < NUM_GPR; i++) map[i] = rec[i*PREG_W +: PREG_W];
        map[0] = '0;
      end else if ((!has || f) && in_i.vld) begin
        q.push_back(in_i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input bit v, input bit s1v, input int s1, input bit s2v, input int s2,
                         input bit dv, input int d);
    in_i.vld = v; in_i.src1_vld = s1v; in_i.src1 = 5'(s1);
    in_i.src2_vld = s2v; in_i.src2 = 5'(s2); in_i.dst_vld = dv; in_i.dst = 5'(d);
    in_i.opcode = 7'($urandom); in_i.funct3 = 3'($urandom); in_i.pc = {$urandom, $urandom};
    in_i.imm_vld = 1'($urandom); in_i.imm = {$urandom, $urandom}; in_i.itype = 6'($urandom);
    in_i.pipe = 5'($urandom); in_i.ras = 1'($urandom);
  endtask

  task automatic res(input bit iv, input int id, input bit pv, input int p);
    iid_vld = iv; iid = IID_W'(id); preg_vld = pv; preg = PREG_W'(p);
  endtask

  initial begin
    for (int i = 0; i < NUM_GPR; i++) rec[i*PREG_W +: PREG_W] = PREG_W'(i);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_strobes", {rob_vld, pst_vld, id_stall}, 3'b000);
    chk("reset_payload", {rob_pc, rob_psrc1, rob_pdst, pst_preg, pst_iid, pst_pre}, '0);
    rst_clk = 1'b0;

    present(1, 1, 1, 0, 0, 1, 5); res(0, 0, 0, 0); tick();
    present(1, 1, 5, 1, 5, 1, 6); res(1, 3, 1, 40); #3;
    chk("addi_fire", {rob_vld, pst_vld}, 2'b11);
    chk("addi_psrc1_pdst", {rob_psrc1, rob_pdst}, {6'd1, 6'd40});
    chk("addi_pst", {pst_gpr, pst_pre, pst_iid}, {5'd5, 6'd5, 4'd3});
    tick();
    present(1, 0, 0, 0, 0, 1, 0); res(1, 4, 1, 41); #3;
    chk("add_rename", {rob_psrc1, rob_psrc2, rob_pdst, pst_pre}, {6'd40, 6'd40, 6'd41, 6'd6});
    tick();
    present(1, 1, 6, 0, 0, 1, 7); res(1, 5, 0, 0); #3;
    chk("x0_write", {rob_vld, pst_vld, rob_dst_vld, rob_pdst}, {1'b1, 1'b0, 1'b0, 6'd0});
    tick();
    present(1, 1, 7, 0, 0, 1, 8); res(1, 6, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #3; chk("preg_starve", {id_stall, rob_vld, pst_vld}, 3'b100); tick();
    end
    res(1, 6, 1, 42); #3;
    chk("starve_release", {rob_vld, rob_psrc1, rob_pdst}, {1'b1, 6'd41, 6'd42});
    tick();
    present(0, 0, 0, 0, 0, 0, 0); res(1, 7, 1, 43); flush = 1'b1;
    for (int i = 1; i < NUM_GPR; i++) rec[i*PREG_W +: PREG_W] = PREG_W'($urandom);
    rec[5*PREG_W +: PREG_W] = 6'd17;
    rec[0 +: PREG_W] = 6'd9;
    #3; chk("flush_no_strobe", {rob_vld, pst_vld}, 2'b00);
    tick();
    flush = 1'b0; present(1, 1, 5, 1, 0, 0, 0); res(0, 0, 0, 0); #3;
    chk("flush_empty", id_stall, 1'b0);
    tick();
    present(0, 0, 0, 0, 0, 0, 0); res(1, 8, 0, 0); #3;
    chk("recovered_map", {rob_vld, rob_psrc1, rob_psrc2}, {1'b1, 6'd17, 6'd0});
    tick();

    present(1, 1, 1, 0, 0, 1, 9); res(0, 0, 0, 0); tick();
    present(0, 0, 0, 0, 0, 0, 0); res(1, 9, 0, 0); #2;
    chk("pre_reset_stall", id_stall, 1'b1);
    #1 rst_clk = 1'b1;
    #2 chk("async_reset", {id_stall, rob_vld, pst_vld}, 3'b000);
    tick();
    rst_clk = 1'b0;
    present(1, 1, 5, 1, 6, 0, 0); res(0, 0, 0, 0); tick();
    res(1, 1, 0, 0); #3;
    chk("reset_identity", {rob_vld, rob_psrc1, rob_psrc2}, {1'b1, 6'd5, 6'd6});
    tick();

    for (int c = 0; c < 400; c++) begin
      present($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 31), 1'($urandom),
              $urandom_range(0, 31), 1'($urandom), $urandom_range(0, 31));
      res($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 7, $urandom);
      stall_ctrl = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 29) == 0);
      if (flush)
        for (int i = 0; i < NUM_GPR; i++) rec[i*PREG_W +: PREG_W] = PREG_W'($urandom);
      tick();
    end
    flush = 1'b0; stall_ctrl = 1'b0;
    present(0, 0, 0, 0, 0, 0, 0); res(1, 2, 1, 33);
    repeat (3) tick();
    chk("drain_no_loss", q.size(), 0);
`ifdef IDU_IR_PERF_EN
    chk("perf_create_cnt", perf_create_cnt, m_create);
    chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/idu_ir_rename.md
Name: idu_ir_rename

Overview:
- Rename stage between the decoder (idu_id) and the retire unit (rtu_rob / rtu_pst_preg).
- Holds one decoded instruction in a single-entry pipeline buffer.
- Obtains an IID from the ROB and, when the instruction writes a register, a free preg from the PST.
- Maps architectural sources and destination through a 32-entry rename table, then drives the ROB create bus and the PST create bus.
- Restores the table from the PST recover snapshot on global flush.

Parameters:
NUM_GPR, 32, architectural register count
PREG_W, 6, physical register index width (64 pregs)
IID_W, 4, ROB instruction id width (16 entries)

Ports:
clk  in  1  core clock
rst_clk  in  1  asynchronous active-high reset
rtu_global_flush  in  1  flush buffer, restore rename table
y_idu_ir_stall_ctrl  in  1  external stall; blocks create
idu_idu_ir_vld  in  1  decoded instruction valid
idu_idu_ir_opcode/funct3/pc/src1_vld/src1/src2_vld/src2/dst_vld/dst/imm_vld/imm/type/pipe/ras  in  7/3/64/1/5/1/5/1/5/1/64/6/5/1  decoded fields
idu_ir_id_stall  out  1  upstream must hold its output
rtu_idu_is_iid_vld  in  1  free IID available
rtu_idu_is_iid  in  IID_W  free IID
rtu_idu_is_preg_vld  in  1  free preg available
rtu_idu_is_preg  in  PREG_W  free preg
rtu_idu_ir_recover_table  in  NUM_GPR*PREG_W  committed map; entry i = bits[6i+5:6i]
idu_rtu_rob_create_vld  out  1  ROB create strobe
idu_rtu_rob_create_opcode/funct3/pc/src1/src1_vld/psrc1/src2/src2_vld/psrc2/dst/dst_vld/pdst/imm/imm_vld/type/pipe/ras  out  matching widths (psrc/pdst PREG_W)  ROB create payload
idu_rtu_pst_create_vld  out  1  PST create strobe
idu_rtu_pst_create_preg_index  out  PREG_W  allocated preg
idu_rtu_pst_create_iid  out  IID_W  owning IID
idu_rtu_pst_create_gpr_index  out  5  architectural dst
idu_rtu_pst_create_gpr_pre_preg_index  out  PREG_W  previous mapping of dst

Behaviour:
- Reset (async, rst_clk=1):
  - buf_vld=0; rename table entry i = i.
  - All create strobes 0; payload outputs 0; idu_ir_id_stall=0.
- need_preg = buf_dst_vld && buf_dst!=0. A write to x0 is treated as dst_vld=0 on both create buses.
- fire = buf_vld && rtu_idu_is_iid_vld && (!need_preg || rtu_idu_is_preg_vld) && !y_idu_ir_stall_ctrl && !rtu_global_flush.
- Accept: when (!buf_vld || fire) && !rtu_global_flush, the buffer loads the decode fields and buf_vld <= idu_idu_ir_vld. Otherwise the buffer holds.
- idu_ir_id_stall = buf_vld && !fire.
- Latency:
  - Instruction presented in cycle N is buffered at edge N.
  - Earliest create is in cycle N+1; strobes are combinational on fire.
- ROB create: vld=fire; payload comes from the buffer.
  - psrcX = table[srcX] when srcX_vld, else 0.
  - pdst = rtu_idu_is_preg if need_preg, else 0.
- PST create:
  - vld = fire && need_preg; preg_index = rtu_idu_is_preg; iid = rtu_idu_is_iid.
  - gpr_index = buf_dst; pre_preg_index = table[buf_dst], read before the update.
- Table update: on PST create, table[buf_dst] <= rtu_idu_is_preg at the clock edge.
  - The next instruction reads the new mapping.
  - At most one create per cycle, so no bypass is needed.
- table[0] is always 0 and never written.
- Flush (has priority over everything):
  - That cycle: buf_vld <= 0, table <= recover_table (entry 0 forced to 0), both strobes 0, decode input dropped.
  - Next cycle: accepts normally.
- A resource that is unavailable stalls without loss. IID/preg values are consumed only in the fire cycle.

Optional Feature:
IDU_IR_PERF_EN:
- Defined: adds outputs perf_create_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_create_cnt increments on each fire.
  - perf_stall_cnt increments each cycle buf_vld && !fire && !rtu_global_flush.
  - Both reset to 0 asynchronously, wrap at 2^32, and are not cleared by flush.
- Undefined: neither port nor logic exists; functional behaviour is identical.

Test Plan:
- Reset, then addi x5,x1,imm with iid=3, preg=40 available:
  - Cycle after accept: rob_create_vld=1, psrc1=1, pdst=40.
  - pst_create: gpr_index=5, pre_preg=5, iid=3.
- Back-to-back: add x6,x5,x5 after the above with preg=41 → psrc1=psrc2=40, pdst=41, pre_preg=6.
- Write to x0 (addi x0,x0,1) with preg_vld=0 → fires; pst_create_vld=0; pdst=0; dst_vld=0; table unchanged.
- preg_vld=0 for 3 cycles with a pending write instruction:
  - idu_ir_id_stall=1 for 3 cycles; no strobe.
  - Fires in the 4th cycle with the preg then offered.
  - Upstream instruction is not lost.
- Flush in the same cycle fire would occur, with recover_table entry 5=17:
  - No strobes; buf_vld=0.
  - A later read of x5 yields psrc1=17.
- Assert rst_clk mid-stall → buf_vld, strobes and stall go 0 immediately; table returns to identity.
- With IDU_IR_PERF_EN: 2 fires plus 3 stall cycles → perf_create_cnt=2, perf_stall_cnt=3.
